// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache-to-memory line adaptor.
package cache_pkg;

  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int offset_bits = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adaptor_state_e;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bundles the cache-side line port and the memory-side burst port of the adaptor.
interface cacheline_adaptor_if #(
  parameter int LINE_W = cache_pkg::LINE_W,
  parameter int BEAT_W = cache_pkg::BEAT_W
);

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic [BEAT_W-1:0] burst_o;
  logic [BEAT_W-1:0] burst_i;
  logic              resp_i;

  // Adaptor view.
  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, resp_i,
    output pmem_rdata, pmem_resp, address_o, read_o, write_o, burst_o
  );

  // Environment view: cache plus memory.
  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, resp_i,
    input  pmem_rdata, pmem_resp, address_o, read_o, write_o, burst_o
  );

endinterface

// File: rtl/line_beat_buffer.sv
// One cache line of storage: whole-line load for writeback, per-beat write for
// fill, and a per-beat read mux feeding the memory write data.
module line_beat_buffer #(
  parameter int LINE_W = cache_pkg::LINE_W,
  parameter int BEAT_W = cache_pkg::BEAT_W,
  parameter int IDX_W  = $clog2(LINE_W / BEAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              beat_we,
  input  logic [IDX_W-1:0]  beat_idx,
  input  logic [BEAT_W-1:0] beat_wdata,
  output logic [BEAT_W-1:0] beat_rdata,
  output logic [LINE_W-1:0] line_q
);

  logic [LINE_W-1:0] buf_q;

  // NOTE: the line buffer is reset even though it is storage, because the
  // cache sees it directly on pmem_rdata and that must read zero out of reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (load) begin
      buf_q <= load_data;
    end else if (beat_we) begin
      buf_q[BEAT_W*int'(beat_idx) +: BEAT_W] <= beat_wdata;
    end
  end

  assign beat_rdata = buf_q[BEAT_W*int'(beat_idx) +: BEAT_W];
  assign line_q     = buf_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// Turns single 256-bit line transfers from the cache into 4-beat 64-bit bursts
// toward memory, gathering fills and serialising writebacks.
module cacheline_adaptor #(
  parameter int LINE_W = cache_pkg::LINE_W,
  parameter int BEAT_W = cache_pkg::BEAT_W
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
);

  import cache_pkg::*;

  localparam int CNT_W = $clog2(LINE_W / BEAT_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((LINE_W / BEAT_W) - 1);
  localparam logic [31:0] ADDR_MASK = ~32'((2 ** offset_bits) - 1);

  adaptor_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;

  logic              buf_load;
  logic              beat_we;
  logic [BEAT_W-1:0] beat_rdata;
  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    buf_load     = 1'b0;
    beat_we      = 1'b0;
    bus.read_o    = 1'b0;
    bus.write_o   = 1'b0;
    bus.pmem_resp = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Writeback wins so a dirty victim leaves before its replacement arrives.
        if (bus.pmem_write) begin
          addr_d   = bus.pmem_address;
          cnt_d    = '0;
          buf_load = 1'b1;
          state_d  = WR_BURST;
        end else if (bus.pmem_read) begin
          addr_d  = bus.pmem_address;
          cnt_d   = '0;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        bus.read_o = 1'b1;
        if (bus.resp_i) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WR_BURST: begin
        bus.write_o = 1'b1;
        if (bus.resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        bus.pmem_resp = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  line_beat_buffer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (CNT_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_data  (bus.pmem_wdata),
    .beat_we    (beat_we),
    .beat_idx   (cnt_q),
    .beat_wdata (bus.burst_i),
    .beat_rdata (beat_rdata),
    .line_q     (line_q)
  );

  // Write data is only presented while a writeback burst is in flight.
  assign bus.burst_o    = (state_q == WR_BURST) ? beat_rdata : '0;
  assign bus.address_o  = addr_q & ADDR_MASK;
  assign bus.pmem_rdata = line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: fill, writeback, stalls, priority,
// mid-burst reset and back-to-back transfers.
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  cacheline_adaptor_if #(.LINE_W(256), .BEAT_W(64)) bus ();

  cacheline_adaptor #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watches for response pulses and read/write overlap during the last test.
  logic mon_en = 1'b0;
  int   resp_pulses = 0;
  int   overlap = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.pmem_resp) resp_pulses++;
      if (bus.read_o && bus.write_o) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0]  b [4];
  logic [255:0] line;
  logic [255:0] wline;

  initial begin
    rst = 1'b1;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.burst_i      = '0;
    bus.resp_i       = 1'b0;
    #12;
    chk("rst_read_o",  bus.read_o, 0);
    chk("rst_write_o", bus.write_o, 0);
    chk("rst_resp",    bus.pmem_resp, 0);
    chk("rst_addr",    bus.address_o, 0);
    chk("rst_burst_o", bus.burst_o, 0);
    chk("rst_rdata",   bus.pmem_rdata, 0);
    rst = 1'b0;
    tick();

    // resp_i while idle must not start anything.
    bus.resp_i = 1'b1;
    tick();
    chk("idle_resp_ignored_rd", bus.read_o, 0);
    chk("idle_resp_ignored_resp", bus.pmem_resp, 0);
    bus.resp_i = 1'b0;

    // ---- Test 1: plain fill ----
    b[0] = 64'h1111_1111_1111_1111;
    b[1] = 64'h2222_2222_2222_2222;
    b[2] = 64'h3333_3333_3333_3333;
    b[3] = 64'h4444_4444_4444_4444;
    line = {b[3], b[2], b[1], b[0]};
    bus.pmem_address = 32'h0000_1234;
    bus.pmem_read    = 1'b1;
    tick();
    chk("fill_read_o", bus.read_o, 1);
    chk("fill_write_o", bus.write_o, 0);
    chk("fill_addr", bus.address_o, 32'h0000_1220);
    for (int i = 0; i < 4; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = b[i];
      tick();
      if (i < 3) chk($sformatf("fill_noresp_%0d", i), bus.pmem_resp, 0);
    end
    chk("fill_resp", bus.pmem_resp, 1);
    chk("fill_read_o_done", bus.read_o, 0);
    chk("fill_rdata", bus.pmem_rdata, line);
    bus.pmem_read = 1'b0;
    bus.resp_i    = 1'b0;
    tick();
    chk("fill_resp_single", bus.pmem_resp, 0);
    chk("fill_idle_read_o", bus.read_o, 0);

    // ---- Test 2: writeback ----
    b[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    b[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    b[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    b[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    wline = {b[3], b[2], b[1], b[0]};
    bus.pmem_address = 32'h0000_ABCD;
    bus.pmem_wdata   = wline;
    bus.pmem_write   = 1'b1;
    tick();
    chk("wb_write_o", bus.write_o, 1);
    chk("wb_read_o", bus.read_o, 0);
    chk("wb_addr", bus.address_o, 32'h0000_ABC0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wb_beat_%0d", i), bus.burst_o, b[i]);
      bus.resp_i = 1'b1;
      tick();
    end
    chk("wb_resp", bus.pmem_resp, 1);
    chk("wb_write_o_done", bus.write_o, 0);
    bus.pmem_write = 1'b0;
    bus.resp_i     = 1'b0;
    tick();
    chk("wb_resp_single", bus.pmem_resp, 0);

    // ---- Test 3: fill with stalls, beats on cycles 1,4,5,9 ----
    b[0] = 64'h0123_4567_89AB_CDEF;
    b[1] = 64'hFEDC_BA98_7654_3210;
    b[2] = 64'h5A5A_5A5A_A5A5_A5A5;
    b[3] = 64'hFFFF_0000_FFFF_0000;
    line = {b[3], b[2], b[1], b[0]};
    bus.pmem_address = 32'hFFFF_FFFF;
    bus.pmem_read    = 1'b1;
    tick();
    chk("gap_addr", bus.address_o, 32'hFFFF_FFE0);
    begin
      int k = 0;
      for (int c = 1; c <= 9; c++) begin
        chk($sformatf("gap_read_o_c%0d", c), bus.read_o, 1);
        chk($sformatf("gap_noresp_c%0d", c), bus.pmem_resp, 0);
        if (c == 1 || c == 4 || c == 5 || c == 9) begin
          bus.resp_i  = 1'b1;
          bus.burst_i = b[k];
          k++;
        end else begin
          bus.resp_i  = 1'b0;
          bus.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        tick();
      end
    end
    chk("gap_resp", bus.pmem_resp, 1);
    chk("gap_rdata", bus.pmem_rdata, line);
    bus.pmem_read = 1'b0;
    bus.resp_i    = 1'b0;
    tick();

    // ---- Test 4: read and write together, write goes first ----
    b[0] = 64'h1000_0000_0000_0001;
    b[1] = 64'h2000_0000_0000_0002;
    b[2] = 64'h3000_0000_0000_0003;
    b[3] = 64'h4000_0000_0000_0004;
    bus.pmem_address = 32'h0000_4000;
    bus.pmem_wdata   = {b[3], b[2], b[1], b[0]};
    bus.pmem_read    = 1'b1;
    bus.pmem_write   = 1'b1;
    tick();
    chk("both_write_o", bus.write_o, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("both_read_o_%0d", i), bus.read_o, 0);
      chk($sformatf("both_beat_%0d", i), bus.burst_o, b[i]);
      bus.resp_i = 1'b1;
      tick();
    end
    chk("both_resp", bus.pmem_resp, 1);
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.resp_i     = 1'b0;
    tick();

    // ---- Test 5: reset in the middle of a fill ----
    bus.pmem_address = 32'h0000_2000;
    bus.pmem_read    = 1'b1;
    tick();
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'h5555_5555_5555_5555;
    tick();
    bus.burst_i = 64'h6666_6666_6666_6666;
    tick();
    bus.resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_read_o", bus.read_o, 0);
    chk("mrst_resp", bus.pmem_resp, 0);
    chk("mrst_addr", bus.address_o, 0);
    chk("mrst_rdata", bus.pmem_rdata, 0);
    tick();
    chk("mrst_hold_resp", bus.pmem_resp, 0);
    chk("mrst_hold_read_o", bus.read_o, 0);
    rst = 1'b0;
    b[0] = 64'h7777_7777_7777_7777;
    b[1] = 64'h8888_8888_8888_8888;
    b[2] = 64'h9999_9999_9999_9999;
    b[3] = 64'hAAAA_5555_AAAA_5555;
    line = {b[3], b[2], b[1], b[0]};
    tick();
    chk("mrst_refill_read_o", bus.read_o, 1);
    chk("mrst_refill_addr", bus.address_o, 32'h0000_2000);
    for (int i = 0; i < 4; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = b[i];
      tick();
    end
    chk("mrst_refill_resp", bus.pmem_resp, 1);
    chk("mrst_refill_rdata", bus.pmem_rdata, line);
    bus.pmem_read = 1'b0;
    bus.resp_i    = 1'b0;
    tick();

    // ---- Test 6: writeback immediately followed by a fill ----
    resp_pulses = 0;
    overlap     = 0;
    mon_en      = 1'b1;
    bus.pmem_address = 32'h0000_8040;
    bus.pmem_wdata   = wline;
    bus.pmem_write   = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.resp_i = 1'b1;
      tick();
    end
    chk("b2b_wb_resp", bus.pmem_resp, 1);
    bus.pmem_write   = 1'b0;
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'h0000_9060;
    bus.resp_i       = 1'b0;
    tick();
    chk("b2b_idle_read_o", bus.read_o, 0);
    chk("b2b_idle_write_o", bus.write_o, 0);
    tick();
    chk("b2b_fill_read_o", bus.read_o, 1);
    chk("b2b_fill_addr", bus.address_o, 32'h0000_9060);
    b[0] = 64'hC0C0_C0C0_C0C0_C0C0;
    b[1] = 64'hC1C1_C1C1_C1C1_C1C1;
    b[2] = 64'hC2C2_C2C2_C2C2_C2C2;
    b[3] = 64'hC3C3_C3C3_C3C3_C3C3;
    line = {b[3], b[2], b[1], b[0]};
    for (int i = 0; i < 4; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = b[i];
      tick();
    end
    chk("b2b_fill_resp", bus.pmem_resp, 1);
    chk("b2b_fill_rdata", bus.pmem_rdata, line);
    bus.pmem_read = 1'b0;
    bus.resp_i    = 1'b0;
    tick();
    tick();
    mon_en = 1'b0;
    chk("b2b_resp_pulses", 256'(resp_pulses), 2);
    chk("b2b_overlap", 256'(overlap), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
